// File: rtl/sample_sequencer.sv
// sample_sequencer
//   Hands ADC samples to a filter chain one at a time and collects the result.
//   IDLE -> TRIG (one-cycle start pulse) -> WAIT (until filter_done or timeout).
//   A sample arriving while a transaction is still open is dropped and flagged.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   adc_data/adc_valid    incoming sample and its one-cycle strobe
//   clear_flags           clears the sticky overrun/timeout flags
//   filt_data/sample_trig sample and start pulse towards the filter chain
//   filt_result/filter_done  result and completion pulse from the chain
//   data_out/data_valid   last accepted result, one-cycle update pulse
//   busy                  high whenever a transaction is open
//   overrun/timeout       sticky error flags
module sample_sequencer #(
  parameter int DATA_SIZE = 24,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] adc_data,
  input  logic                 adc_valid,
  input  logic                 clear_flags,
  output logic [DATA_SIZE-1:0] filt_data,
  output logic                 sample_trig,
  input  logic [DATA_SIZE-1:0] filt_result,
  input  logic                 filter_done,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] filt_data_q, filt_data_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    filt_data_d  = filt_data_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    // Clear first; any set condition below overrides it on the same edge.
    overrun_d    = overrun_q & ~clear_flags;
    timeout_d    = timeout_q & ~clear_flags;

    case (state_q)
      IDLE: begin
        // filter_done is deliberately ignored here.
        if (adc_valid) begin
          filt_data_d = adc_data;
          state_d     = TRIG;
        end
      end
      TRIG: begin
        if (adc_valid) overrun_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (adc_valid) overrun_d = 1'b1;
        // filter_done on the final wait cycle still wins over the timeout.
        if (filter_done) begin
          data_out_d   = filt_result;
          data_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      filt_data_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      filt_data_q  <= filt_data_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign filt_data   = filt_data_q;
  assign sample_trig = (state_q == TRIG);
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer
//   Directed bench: one sequencer with the default TIMEOUT and one with
//   TIMEOUT=4 share the same stimulus. The filter chain is emulated in the
//   stimulus: fixed latency after sample_trig, result = sample ^ 24'h5A5A5A.
module tb_sample_sequencer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] adc_data, filt_result;
  logic          adc_valid, clear_flags, filter_done;

  logic [DW-1:0] filt_data, data_out;
  logic          sample_trig, data_valid, busy, overrun, timeout;
  logic [DW-1:0] t4_filt_data, t4_data_out;
  logic          t4_sample_trig, t4_data_valid, t4_busy, t4_overrun, t4_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sample_sequencer #(.DATA_SIZE(DW), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .clear_flags(clear_flags), .filt_data(filt_data), .sample_trig(sample_trig),
    .filt_result(filt_result), .filter_done(filter_done), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  sample_sequencer #(.DATA_SIZE(DW), .TIMEOUT(4)) u_t4 (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .clear_flags(clear_flags), .filt_data(t4_filt_data), .sample_trig(t4_sample_trig),
    .filt_result(filt_result), .filter_done(filter_done), .data_out(t4_data_out),
    .data_valid(t4_data_valid), .busy(t4_busy), .overrun(t4_overrun), .timeout(t4_timeout)
  );

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".filt_data"},   32'(filt_data),   32'h0);
    chk({tag, ".data_out"},    32'(data_out),    32'h0);
    chk({tag, ".sample_trig"}, 32'(sample_trig), 32'h0);
    chk({tag, ".data_valid"},  32'(data_valid),  32'h0);
    chk({tag, ".busy"},        32'(busy),        32'h0);
    chk({tag, ".overrun"},     32'(overrun),     32'h0);
    chk({tag, ".timeout"},     32'(timeout),     32'h0);
  endtask

  initial begin
    logic [DW-1:0] smp [3];
    smp[0] = 24'h800001; smp[1] = 24'h7FFFFE; smp[2] = 24'hC0FFEE;

    reset = 1'b1; adc_data = '0; adc_valid = 1'b0; clear_flags = 1'b0;
    filt_result = '0; filter_done = 1'b0;

    // ---- reset state
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;

    // ---- nominal transaction
    step(); step();
    adc_data = 24'h012345; adc_valid = 1'b1;
    step();                                   // TRIG cycle
    chk("nom.trig",  32'(sample_trig), 32'h1);
    chk("nom.filt",  32'(filt_data),   32'h012345);
    chk("nom.busy",  32'(busy),        32'h1);
    adc_valid = 1'b0; adc_data = 24'hFFFFFF;
    step();                                   // first WAIT cycle
    for (int i = 0; i < 9; i++) begin
      chk("nom.wait_trig", 32'(sample_trig), 32'h0);
      chk("nom.wait_busy", 32'(busy),        32'h1);
      if (i == 8) begin
        filter_done = 1'b1; filt_result = 24'h0ABCDE;
      end
      step();
    end
    filter_done = 1'b0; filt_result = 24'h123123;
    chk("nom.dv",       32'(data_valid), 32'h1);
    chk("nom.dout",     32'(data_out),   32'h0ABCDE);
    chk("nom.busy_end", 32'(busy),       32'h0);
    chk("nom.filt_hold",32'(filt_data),  32'h012345);
    step();
    chk("nom.dv_once",  32'(data_valid), 32'h0);
    chk("nom.dout_hold",32'(data_out),   32'h0ABCDE);

    // ---- overrun during WAIT
    adc_data = 24'h111111; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    step();                                   // WAIT
    adc_data = 24'h222222; adc_valid = 1'b1;
    step();
    chk("ovr.flag", 32'(overrun),   32'h1);
    chk("ovr.filt", 32'(filt_data), 32'h111111);
    chk("ovr.busy", 32'(busy),      32'h1);
    adc_valid = 1'b0; filter_done = 1'b1; filt_result = 24'h333333;
    step();
    filter_done = 1'b0;
    chk("ovr.dv",   32'(data_valid), 32'h1);
    chk("ovr.dout", 32'(data_out),   32'h333333);
    chk("ovr.sticky", 32'(overrun),  32'h1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("ovr.clear", 32'(overrun), 32'h0);

    // ---- timeout (TIMEOUT=4 instance)
    reset = 1'b1;
    step();
    reset = 1'b0;
    adc_data = 24'h444444; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    step();
    filter_done = 1'b1; filt_result = 24'h555555;
    step();
    filter_done = 1'b0;
    chk("to.prior_dout", 32'(t4_data_out), 32'h555555);
    adc_valid = 1'b1;
    step();                                   // TRIG
    adc_valid = 1'b0;
    step(); step(); step(); step();           // WAIT cnt 0..3
    chk("to.busy_last", 32'(t4_busy),    32'h1);
    chk("to.not_yet",   32'(t4_timeout), 32'h0);
    step();
    chk("to.flag",  32'(t4_timeout),    32'h1);
    chk("to.idle",  32'(t4_busy),       32'h0);
    chk("to.no_dv", 32'(t4_data_valid), 32'h0);
    chk("to.dout",  32'(t4_data_out),   32'h555555);
    clear_flags = 1'b1; adc_valid = 1'b1;
    step();                                   // TRIG, flag cleared
    clear_flags = 1'b0; adc_valid = 1'b0;
    chk("to.cleared", 32'(t4_timeout), 32'h0);
    step(); step(); step(); step();           // WAIT cnt 0..3
    filter_done = 1'b1; filt_result = 24'h666666;
    step();
    filter_done = 1'b0;
    chk("to.last_dv",   32'(t4_data_valid), 32'h1);
    chk("to.last_dout", 32'(t4_data_out),   32'h666666);
    chk("to.last_flag", 32'(t4_timeout),    32'h0);

    // ---- simultaneous filter_done + adc_valid in WAIT
    adc_data = 24'h777777; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    step();
    adc_data = 24'h888888; adc_valid = 1'b1;
    filter_done = 1'b1; filt_result = 24'h999999;
    step();
    adc_valid = 1'b0; filter_done = 1'b0;
    chk("sim.dv",   32'(data_valid), 32'h1);
    chk("sim.dout", 32'(data_out),   32'h999999);
    chk("sim.ovr",  32'(overrun),    32'h1);
    chk("sim.filt", 32'(filt_data),  32'h777777);
    chk("sim.busy", 32'(busy),       32'h0);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("sim.clear", 32'(overrun), 32'h0);
    adc_data = 24'hAAAAAA; adc_valid = 1'b1;
    step();                                   // TRIG
    adc_data = 24'hBBBBBB; clear_flags = 1'b1;
    step();                                   // drop + clear on same edge
    adc_valid = 1'b0; clear_flags = 1'b0;
    chk("sim.set_wins", 32'(overrun),   32'h1);
    chk("sim.filt2",    32'(filt_data), 32'hAAAAAA);

    // ---- reset mid-WAIT, late filter_done ignored
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rst_mid");
    filter_done = 1'b1; filt_result = 24'hCCCCCC;
    step();
    filter_done = 1'b0;
    chk("rst.late_dv",   32'(data_valid), 32'h0);
    chk("rst.late_dout", 32'(data_out),   32'h0);
    chk("rst.late_busy", 32'(busy),       32'h0);

    // ---- sample on first edge after reset release
    reset = 1'b1;
    step();
    reset = 1'b0; adc_data = 24'hDDDDDD; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    chk("rel.trig", 32'(sample_trig), 32'h1);
    chk("rel.filt", 32'(filt_data),   32'hDDDDDD);

    // ---- chain with emulated filter, samples spaced beyond its latency
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adc_data = smp[k]; adc_valid = 1'b1;
      step();
      adc_valid = 1'b0;
      chk("chain.trig", 32'(sample_trig), 32'h1);
      step(); step();
      filter_done = 1'b1; filt_result = filt_data ^ 24'h5A5A5A;
      step();
      filter_done = 1'b0;
      chk("chain.dv",   32'(data_valid), 32'h1);
      chk("chain.dout", 32'(data_out),   32'(smp[k] ^ 24'h5A5A5A));
      step();
      chk("chain.dv_once", 32'(data_valid), 32'h0);
      step();
    end
    chk("chain.ovr",    32'(overrun),    32'h0);
    chk("chain.to",     32'(timeout),    32'h0);
    chk("chain.t4_to",  32'(t4_timeout), 32'h0);
    chk("chain.t4_ovr", 32'(t4_overrun), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 24: sample and result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255: the maximum number of cycles spent waiting for filter_done, legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port adc_data, input, DATA_SIZE bits: the converter sample, valid when adc_valid=1.
REQ-006 SHALL have port adc_valid, input, 1 bit: a one-cycle new-sample strobe.
REQ-007 SHALL have port clear_flags, input, 1 bit: clears the sticky error flags.
REQ-008 SHALL have port filt_data, output, DATA_SIZE bits: the sample presented to the filter chain's data_in.
REQ-009 SHALL have port sample_trig, output, 1 bit: a one-cycle start pulse to the filter chain.
REQ-010 SHALL have port filt_result, input, DATA_SIZE bits: the filter chain's data_out.
REQ-011 SHALL have port filter_done, input, 1 bit: the completion pulse from the last filter stage.
REQ-012 SHALL have port data_out, output, DATA_SIZE bits: the last accepted filter result, held between updates.
REQ-013 SHALL have port data_valid, output, 1 bit: a one-cycle pulse when data_out updates.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port overrun, output, 1 bit: sticky; set when a sample is dropped.
REQ-016 SHALL have port timeout, output, 1 bit: sticky; set when the filter fails to respond.

Function
REQ-017 SHALL implement the FSM states IDLE, TRIG and WAIT, with a wait counter of ceil(log2(TIMEOUT+1)) bits.
REQ-018 In IDLE with adc_valid=1 at an edge, SHALL latch adc_data into filt_data and enter TRIG.
REQ-019 SHALL drive sample_trig=1 for exactly the single TRIG cycle, with filt_data already stable in that cycle, and SHALL then enter WAIT with the counter at 0.
REQ-020 filt_data SHALL remain constant from TRIG until the next accepted sample.
REQ-021 In WAIT with filter_done=1 at an edge, SHALL register filt_result into data_out, pulse data_valid in the following cycle, and return to IDLE.
REQ-022 Accept latency: adc_valid sampled at edge N SHALL give sample_trig=1 in cycle N+1; filter_done sampled at edge M SHALL give data_valid=1 and the new data_out in cycle M+1.
REQ-023 In WAIT without filter_done, SHALL increment the counter; when counter=TIMEOUT-1 with no filter_done, SHALL set timeout, return to IDLE, and leave data_out unchanged with no data_valid pulse.
REQ-024 WAIT SHALL therefore last at most TIMEOUT cycles; filter_done in the last WAIT cycle SHALL win over timeout.
REQ-025 adc_valid=1 while not in IDLE (TRIG or WAIT), including the same edge as filter_done, SHALL drop that sample, set overrun, and leave filt_data untouched.
REQ-026 filter_done in IDLE or TRIG SHALL be ignored: no data_out change, no flag change.
REQ-027 clear_flags=1 SHALL clear overrun and timeout at that edge; if a set condition occurs on the same edge, set SHALL win.
REQ-028 SHALL perform no arithmetic on the data path; samples and results pass bit-exact, no sign extension or truncation.

Reset
REQ-029 reset=1 at an edge SHALL force state IDLE, counter 0, and filt_data, data_out, sample_trig, data_valid, busy, overrun and timeout all to 0, overriding every other input.
REQ-030 Reset mid-operation (TRIG or WAIT) SHALL abort the transaction; a filter_done arriving after reset release SHALL be ignored per REQ-026.
REQ-031 adc_valid on the first edge after reset is released SHALL be accepted normally.

Verification
REQ-032 Nominal: adc_data=24'h012345 with adc_valid at edge 10, filter_done at edge 20 with filt_result=24'h0ABCDE -> sample_trig high in cycle 11 only, filt_data=24'h012345, data_out=24'h0ABCDE and data_valid high in cycle 21 only, busy high in cycles 11..20.
REQ-033 Overrun: second adc_valid during WAIT -> overrun=1, filt_data unchanged, the first transaction completes normally; clear_flags -> overrun=0 next cycle.
REQ-034 Timeout: TIMEOUT=4, no filter_done -> timeout=1 after 4 WAIT cycles, state IDLE, no data_valid, data_out keeps its prior value; filter_done on the 4th WAIT cycle instead -> data_valid pulse, timeout stays 0.
REQ-035 Simultaneous: filter_done and adc_valid on the same WAIT edge -> result captured, sample dropped, overrun=1; clear_flags together with an overrun event -> overrun stays 1.
REQ-036 Reset mid-WAIT: reset pulse, then filter_done -> all outputs 0, no data_valid, busy=0.
REQ-037 Chain: connected to the two-stage notch filter with back-to-back samples spaced beyond the filter latency -> one data_valid per sample, and no overrun or timeout.
